// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the address translation slice.
//   exc_code_e   : translation exception codes reported with each response
//   state_e      : translator FSM states (exposed on dbg_state)
//   utlb_entry_t : one micro-TLB entry
//   DMW_*        : bit positions of the fields inside a direct-mapped window CSR
//   exc_check()  : exception priority for a TLB-sourced translation
package mmu_pkg;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_TLBR = 3'd1,
        EXC_PIL  = 3'd2,
        EXC_PIS  = 3'd3,
        EXC_PPI  = 3'd4,
        EXC_PME  = 3'd5
    } exc_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] pfn;
        logic [1:0]  mat;
        logic        d;
        logic [1:0]  plv;
        logic        valid;
    } utlb_entry_t;

    // Direct-mapped window CSR layout
    localparam int DMW_VSEG_HI = 31;
    localparam int DMW_VSEG_LO = 29;
    localparam int DMW_PSEG_HI = 27;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_MAT_HI  = 5;
    localparam int DMW_MAT_LO  = 4;
    localparam int DMW_PLV_HI  = 3;   // one enable bit per privilege level
    localparam int DMW_PLV_LO  = 0;

    // First failing check wins: missing entry, invalid page, privilege, dirty.
    function automatic exc_code_e exc_check(input logic       found,
                                            input logic       v,
                                            input logic       d,
                                            input logic       is_store,
                                            input logic [1:0] entry_plv,
                                            input logic [1:0] req_plv);
        exc_code_e code;
        if (!found)                  code = EXC_TLBR;
        else if (!v)                 code = is_store ? EXC_PIS : EXC_PIL;
        else if (req_plv > entry_plv) code = EXC_PPI;
        else if (is_store && !d)     code = EXC_PME;
        else                         code = EXC_NONE;
        return code;
    endfunction

endpackage

// File: rtl/mmu_xlate_if.sv
// mmu_xlate_if: request, response and main-TLB lookup signals of the translator.
//   slave  : the translator (mmu_xlate)
//   master : the requester / main TLB side
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where both valid and ready are 1. Once valid is raised it
// stays high, with its payload unchanged, until that transfer. The main-TLB
// lookup is a request/response pair: tlb_req_valid and tlb_vpn stay asserted
// and stable until a single-cycle tlb_resp_valid pulse returns the result.
interface mmu_xlate_if;
    import mmu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] vaddr;
    logic        is_store;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] paddr;
    logic [1:0]  mat;
    logic        is_dmw;
    logic        is_usetlb;
    exc_code_e   exc_code;

    logic        tlb_req_valid;
    logic [19:0] tlb_vpn;
    logic        tlb_resp_valid;
    logic        tlb_found;
    logic [19:0] tlb_pfn;
    logic [1:0]  tlb_mat;
    logic        tlb_v;
    logic        tlb_d;
    logic [1:0]  tlb_plv;

    modport slave (
        input  req_valid, vaddr, is_store, resp_ready,
        input  tlb_resp_valid, tlb_found, tlb_pfn, tlb_mat, tlb_v, tlb_d, tlb_plv,
        output req_ready, resp_valid, paddr, mat, is_dmw, is_usetlb, exc_code,
        output tlb_req_valid, tlb_vpn
    );

    modport master (
        output req_valid, vaddr, is_store, resp_ready,
        output tlb_resp_valid, tlb_found, tlb_pfn, tlb_mat, tlb_v, tlb_d, tlb_plv,
        input  req_ready, resp_valid, paddr, mat, is_dmw, is_usetlb, exc_code,
        input  tlb_req_valid, tlb_vpn
    );

endinterface

// File: rtl/mmu_utlb.sv
// mmu_utlb: fully associative micro-TLB (entry array, parallel lookup, victim pick).
// Build option: MMU_UTLB_EN. When undefined there is no storage and every
// lookup misses.
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : clear every valid bit this cycle (beats a same-cycle write)
//   lookup_vpn  : virtual page number to look up (combinational)
//   hit         : lookup_vpn matches a valid entry
//   hit_entry   : the matching entry (lowest index if several)
//   wr_en       : install wr_entry into the victim slot
//   wr_entry    : entry to install
module mmu_utlb import mmu_pkg::*; #(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [19:0] lookup_vpn,
    output logic        hit,
    output utlb_entry_t hit_entry,
    input  logic        wr_en,
    input  utlb_entry_t wr_entry
);

`ifdef MMU_UTLB_EN
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    utlb_entry_t   entries [ENTRIES];
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] victim;
    logic          free_found;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_entry = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (entries[i].valid && (entries[i].vpn == lookup_vpn)) begin
                hit       = 1'b1;
                hit_entry = entries[i];
            end
        end
    end

    // Prefer the first empty slot; only evict via round-robin when full.
    always_comb begin
        victim     = rr_ptr;
        free_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!free_found && !entries[i].valid) begin
                victim     = IW'(i);
                free_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
        end else if (wr_en) begin
            entries[victim] <= wr_entry;
            rr_ptr          <= rr_ptr + 1'b1;   // ENTRIES is a power of two: wraps
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, resetn, flush, lookup_vpn, wr_en, wr_entry};
    assign hit       = 1'b0;
    assign hit_entry = '0;
`endif

endmodule

// File: rtl/mmu_xlate.sv
// mmu_xlate: virtual-to-physical address translation front end.
// Order of resolution at request acceptance: direct addressing (da=1, pg=0),
// then direct-mapped windows, then the micro-TLB; a miss walks the main TLB
// in REFILL. Build option: MMU_UTLB_EN enables the micro-TLB (see mmu_utlb).
//   clk, resetn : clock, asynchronous active-low reset
//   da, pg, plv, mat_csr, dmw : CSR state, captured when a request is accepted
//   flush       : invalidate the micro-TLB
//   bus         : request / response / main-TLB lookup (mmu_xlate_if.slave)
//   dbg_state   : current FSM state
module mmu_xlate import mmu_pkg::*; #(
    parameter int NUM_DMW      = 2,
    parameter int UTLB_ENTRIES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    da,
    input  logic                    pg,
    input  logic [1:0]              plv,
    input  logic [1:0]              mat_csr,
    input  logic [NUM_DMW-1:0][31:0] dmw,
    input  logic                    flush,
    mmu_xlate_if.slave              bus,
    output state_e                  dbg_state
);

    state_e      state, state_nx;
    logic        accept;

    // Transaction context captured at acceptance, used by REFILL
    logic [31:0] vaddr_q;
    logic        is_store_q;
    logic [1:0]  plv_q;
    logic        flush_seen;   // a flush landed during this refill: do not install

    // Response registers and their next values
    logic [31:0] paddr_q, paddr_nx;
    logic [1:0]  mat_q, mat_nx;
    logic        is_dmw_q, is_dmw_nx;
    logic        is_usetlb_q, is_usetlb_nx;
    exc_code_e   exc_q, exc_nx;

    // Window match
    logic        win_hit;
    logic [2:0]  win_pseg;
    logic [1:0]  win_mat;
    logic [3:0]  win_plv_en;

    // Micro-TLB
    logic        utlb_hit;
    utlb_entry_t utlb_e;
    logic        utlb_wr;
    utlb_entry_t utlb_wr_entry;

    logic        unused_ok;
    assign unused_ok = ^{dmw, utlb_e.vpn, utlb_e.valid};

    assign bus.req_ready = (state == ST_IDLE) || ((state == ST_RESP) && bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Descending scan so the lowest matching window wins.
    always_comb begin
        win_hit    = 1'b0;
        win_pseg   = '0;
        win_mat    = '0;
        win_plv_en = '0;
        for (int i = NUM_DMW - 1; i >= 0; i--) begin
            win_plv_en = dmw[i][DMW_PLV_HI:DMW_PLV_LO];
            if ((bus.vaddr[31:29] == dmw[i][DMW_VSEG_HI:DMW_VSEG_LO]) && win_plv_en[plv]) begin
                win_hit  = 1'b1;
                win_pseg = dmw[i][DMW_PSEG_HI:DMW_PSEG_LO];
                win_mat  = dmw[i][DMW_MAT_HI:DMW_MAT_LO];
            end
        end
    end

    mmu_utlb #(.ENTRIES(UTLB_ENTRIES)) u_utlb (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .lookup_vpn (bus.vaddr[31:12]),
        .hit        (utlb_hit),
        .hit_entry  (utlb_e),
        .wr_en      (utlb_wr),
        .wr_entry   (utlb_wr_entry)
    );

    always_comb begin
        utlb_wr_entry       = '0;
        utlb_wr_entry.vpn   = vaddr_q[31:12];
        utlb_wr_entry.pfn   = bus.tlb_pfn;
        utlb_wr_entry.mat   = bus.tlb_mat;
        utlb_wr_entry.d     = bus.tlb_d;
        utlb_wr_entry.plv   = bus.tlb_plv;
        utlb_wr_entry.valid = 1'b1;
    end

    // Next state and response values
    always_comb begin
        state_nx     = state;
        paddr_nx     = paddr_q;
        mat_nx       = mat_q;
        is_dmw_nx    = is_dmw_q;
        is_usetlb_nx = is_usetlb_q;
        exc_nx       = exc_q;
        utlb_wr      = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if ((state == ST_RESP) && bus.resp_ready) state_nx = ST_IDLE;
                if (accept) begin
                    if (da && !pg) begin
                        state_nx     = ST_RESP;
                        paddr_nx     = bus.vaddr;
                        mat_nx       = mat_csr;
                        is_dmw_nx    = 1'b0;
                        is_usetlb_nx = 1'b0;
                        exc_nx       = EXC_NONE;
                    end else if (win_hit) begin
                        state_nx     = ST_RESP;
                        paddr_nx     = {win_pseg, bus.vaddr[28:0]};
                        mat_nx       = win_mat;
                        is_dmw_nx    = 1'b1;
                        is_usetlb_nx = 1'b0;
                        exc_nx       = EXC_NONE;
                    end else if (utlb_hit) begin
                        // Resident entries were installed with found=1, v=1.
                        state_nx     = ST_RESP;
                        paddr_nx     = {utlb_e.pfn, bus.vaddr[11:0]};
                        mat_nx       = utlb_e.mat;
                        is_dmw_nx    = 1'b0;
                        is_usetlb_nx = 1'b1;
                        exc_nx       = exc_check(1'b1, 1'b1, utlb_e.d, bus.is_store,
                                                 utlb_e.plv, plv);
                    end else begin
                        state_nx = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (bus.tlb_resp_valid) begin
                    state_nx     = ST_RESP;
                    paddr_nx     = {bus.tlb_pfn, vaddr_q[11:0]};
                    mat_nx       = bus.tlb_mat;
                    is_dmw_nx    = 1'b0;
                    is_usetlb_nx = 1'b1;
                    exc_nx       = exc_check(bus.tlb_found, bus.tlb_v, bus.tlb_d,
                                             is_store_q, bus.tlb_plv, plv_q);
                    utlb_wr      = bus.tlb_found && bus.tlb_v && !flush_seen;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            vaddr_q     <= '0;
            is_store_q  <= 1'b0;
            plv_q       <= '0;
            flush_seen  <= 1'b0;
            paddr_q     <= '0;
            mat_q       <= '0;
            is_dmw_q    <= 1'b0;
            is_usetlb_q <= 1'b0;
            exc_q       <= EXC_NONE;
        end else begin
            state       <= state_nx;
            paddr_q     <= paddr_nx;
            mat_q       <= mat_nx;
            is_dmw_q    <= is_dmw_nx;
            is_usetlb_q <= is_usetlb_nx;
            exc_q       <= exc_nx;
            if (accept) begin
                vaddr_q    <= bus.vaddr;
                is_store_q <= bus.is_store;
                plv_q      <= plv;
                flush_seen <= 1'b0;
            end else if ((state == ST_REFILL) && flush) begin
                flush_seen <= 1'b1;
            end
        end
    end

    assign bus.resp_valid    = (state == ST_RESP);
    assign bus.tlb_req_valid = (state == ST_REFILL);
    assign bus.tlb_vpn       = vaddr_q[31:12];
    assign bus.paddr         = paddr_q;
    assign bus.mat           = mat_q;
    assign bus.is_dmw        = is_dmw_q;
    assign bus.is_usetlb     = is_usetlb_q;
    assign bus.exc_code      = exc_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_mmu_xlate.sv
// tb_mmu_xlate: directed bench for mmu_xlate with an expected-response queue.
// Honours MMU_UTLB_EN: with it, repeated pages are expected to hit with
// latency 1; without it, every mapped request is expected to refill.
module tb_mmu_xlate;
    import mmu_pkg::*;

    localparam int NDMW  = 2;
    localparam int NUTLB = 4;

`ifdef MMU_UTLB_EN
    localparam bit HIT_REFILL = 1'b0;
`else
    localparam bit HIT_REFILL = 1'b1;
`endif

    typedef struct packed {
        logic        found;
        logic [19:0] pfn;
        logic [1:0]  mat;
        logic        v;
        logic        d;
        logic [1:0]  plv;
    } rsp_t;

    localparam rsp_t NORSP = '0;

    // clock / reset
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic                 da, pg, flush;
    logic [1:0]           plv, mat_csr;
    logic [NDMW-1:0][31:0] dmw;
    state_e               dbg_state;

    mmu_xlate_if bus ();

    mmu_xlate #(.NUM_DMW(NDMW), .UTLB_ENTRIES(NUTLB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .da        (da),
        .pg        (pg),
        .plv       (plv),
        .mat_csr   (mat_csr),
        .dmw       (dmw),
        .flush     (flush),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // scoreboard
    logic [38:0] exp_q[$];
    logic [38:0] msk_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] pk(input logic [31:0] pa, input logic [1:0] m,
                                       input logic dm, input logic u, input exc_code_e x);
        return {pa, m, dm, u, x};
    endfunction

    function automatic logic [38:0] observed();
        return {bus.paddr, bus.mat, bus.is_dmw, bus.is_usetlb, bus.exc_code};
    endfunction

    // One request. refill: a main-TLB lookup is expected; rsp is returned
    // after delay cycles. stall: cycles resp_ready is held low. scramble: CSRs
    // are disturbed right after acceptance. flush_mid: flush pulse in REFILL.
    task automatic xact(input string tag, input logic [31:0] va, input logic st,
                        input logic refill, input int delay, input rsp_t rsp,
                        input logic [38:0] e, input int stall,
                        input logic scramble, input logic flush_mid);
        logic acc;
        logic [38:0] ev, mv;
        logic sda, spg;
        logic [1:0] splv, smat;
        logic [NDMW-1:0][31:0] sdmw;
        exp_q.push_back(e);
        msk_q.push_back((e[2:0] == 3'(EXC_NONE)) ? {39{1'b1}} : 39'h1F);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.vaddr      = va;
        bus.is_store   = st;
        bus.resp_ready = (stall == 0);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            acc = bus.req_ready;
        end
        chk({tag, "_accept"}, acc, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        sda = da; spg = pg; splv = plv; smat = mat_csr; sdmw = dmw;
        if (scramble) begin
            da = 1'b1; pg = 1'b0; plv = 2'd3; mat_csr = 2'd3; dmw = '0;
        end
        @(negedge clk);
        if (refill) begin
            chk({tag, "_treq"}, bus.tlb_req_valid, 1);
            chk({tag, "_tvpn"}, bus.tlb_vpn, va[31:12]);
            for (int i = 0; i < delay; i++) begin
                if (flush_mid && i == 0) flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                @(negedge clk);
                chk({tag, "_thold"}, {bus.tlb_req_valid, bus.resp_valid, bus.tlb_vpn},
                    {1'b1, 1'b0, va[31:12]});
            end
            bus.tlb_resp_valid = 1'b1;
            bus.tlb_found = rsp.found; bus.tlb_pfn = rsp.pfn; bus.tlb_mat = rsp.mat;
            bus.tlb_v = rsp.v; bus.tlb_d = rsp.d; bus.tlb_plv = rsp.plv;
            @(posedge clk); #1;
            bus.tlb_resp_valid = 1'b0;
            @(negedge clk);
        end else begin
            chk({tag, "_notreq"}, bus.tlb_req_valid, 0);
        end
        chk({tag, "_rvalid"}, bus.resp_valid, 1);
        ev = exp_q.pop_front();
        mv = msk_q.pop_front();
        chk({tag, "_rsp"}, 64'(observed() & mv), 64'(ev & mv));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall"}, {bus.resp_valid, observed()}, {1'b1, ev});
        end
        bus.resp_ready = 1'b1;
        da = sda; pg = spg; plv = splv; mat_csr = smat; dmw = sdmw;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        da = 1'b0; pg = 1'b1; plv = 2'd0; mat_csr = 2'd0; dmw = '0; flush = 1'b0;
        bus.req_valid = 1'b0; bus.vaddr = '0; bus.is_store = 1'b0; bus.resp_ready = 1'b1;
        bus.tlb_resp_valid = 1'b0; bus.tlb_found = 1'b0; bus.tlb_pfn = '0;
        bus.tlb_mat = '0; bus.tlb_v = 1'b0; bus.tlb_d = 1'b0; bus.tlb_plv = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_out", {bus.resp_valid, bus.tlb_req_valid, observed()},
            {1'b0, 1'b0, pk(32'h0, 2'd0, 1'b0, 1'b0, EXC_NONE)});
        chk("rst_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        resetn = 1'b1;

        // direct addressing, CSRs scrambled after acceptance
        da = 1'b1; pg = 1'b0; mat_csr = 2'd1;
        xact("da", 32'h1C00_0100, 1'b0, 1'b0, 0, NORSP,
             pk(32'h1C00_0100, 2'd1, 1'b0, 1'b0, EXC_NONE), 0, 1'b1, 1'b0);
        da = 1'b0; pg = 1'b1; mat_csr = 2'd0;

        // direct-mapped windows
        dmw[0] = 32'h0000_0001; dmw[1] = 32'hA000_0011;
        xact("dmw1", 32'hA123_4567, 1'b0, 1'b0, 0, NORSP,
             pk(32'h0123_4567, 2'd1, 1'b1, 1'b0, EXC_NONE), 0, 1'b1, 1'b0);
        dmw[0] = 32'hA200_0021;
        xact("dmw_low", 32'hA123_4567, 1'b0, 1'b0, 0, NORSP,
             pk(32'h2123_4567, 2'd2, 1'b1, 1'b0, EXC_NONE), 0, 1'b0, 1'b0);

        // privilege not enabled in any window -> main TLB, not found twice
        plv = 2'd3;
        xact("tlbr1", 32'hA123_4567, 1'b0, 1'b1, 1, NORSP,
             pk(32'h0, 2'd0, 1'b0, 1'b1, EXC_TLBR), 0, 1'b0, 1'b0);
        xact("tlbr2", 32'hA123_4567, 1'b0, 1'b1, 0, NORSP,
             pk(32'h0, 2'd0, 1'b0, 1'b1, EXC_TLBR), 0, 1'b0, 1'b0);
        plv = 2'd0; dmw = '0;

        // miss then repeat on the same page
        xact("miss", 32'h0040_2008, 1'b0, 1'b1, 3, '{1'b1, 20'h12345, 2'd1, 1'b1, 1'b1, 2'd0},
             pk(32'h1234_5008, 2'd1, 1'b0, 1'b1, EXC_NONE), 0, 1'b1, 1'b0);
        xact("rehit", 32'h0040_2ABC, 1'b0, HIT_REFILL, 1, '{1'b1, 20'h12345, 2'd1, 1'b1, 1'b1, 2'd0},
             pk(32'h1234_5ABC, 2'd1, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);

        // clean page, then a store to it
        xact("ld_clean", 32'h0050_0010, 1'b0, 1'b1, 2, '{1'b1, 20'h00ABC, 2'd2, 1'b1, 1'b0, 2'd0},
             pk(32'h00AB_C010, 2'd2, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);
        xact("st_pme", 32'h0050_0020, 1'b1, HIT_REFILL, 1, '{1'b1, 20'h00ABC, 2'd2, 1'b1, 1'b0, 2'd0},
             pk(32'h0, 2'd0, 1'b0, 1'b1, EXC_PME), 0, 1'b0, 1'b0);

        // invalid page
        xact("pil", 32'h0060_0000, 1'b0, 1'b1, 1, '{1'b1, 20'h00666, 2'd0, 1'b0, 1'b1, 2'd0},
             pk(32'h0, 2'd0, 1'b0, 1'b1, EXC_PIL), 0, 1'b0, 1'b0);
        xact("pis", 32'h0060_0004, 1'b1, 1'b1, 1, '{1'b1, 20'h00666, 2'd0, 1'b0, 1'b1, 2'd0},
             pk(32'h0, 2'd0, 1'b0, 1'b1, EXC_PIS), 0, 1'b0, 1'b0);

        // privilege violation
        plv = 2'd3;
        xact("ppi", 32'h0070_0000, 1'b1, 1'b1, 1, '{1'b1, 20'h00777, 2'd0, 1'b1, 1'b0, 2'd0},
             pk(32'h0, 2'd0, 1'b0, 1'b1, EXC_PPI), 0, 1'b0, 1'b0);
        plv = 2'd0;

        // backpressure: outputs hold for 4 cycles
        dmw[1] = 32'hA000_0011;
        xact("stall", 32'hA000_0010, 1'b0, 1'b0, 0, NORSP,
             pk(32'h0000_0010, 2'd1, 1'b1, 1'b0, EXC_NONE), 4, 1'b0, 1'b0);
        dmw = '0;

        // flush, then a formerly resident page refills
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        xact("post_flush", 32'h0040_2008, 1'b0, 1'b1, 1, '{1'b1, 20'h12345, 2'd1, 1'b1, 1'b1, 2'd0},
             pk(32'h1234_5008, 2'd1, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);

        // flush during refill: response delivered, entry not installed
        xact("flush_mid", 32'h0080_0000, 1'b0, 1'b1, 2, '{1'b1, 20'h00888, 2'd0, 1'b1, 1'b1, 2'd0},
             pk(32'h0088_8000, 2'd0, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b1);
        xact("flush_mid_re", 32'h0080_0100, 1'b0, 1'b1, 1, '{1'b1, 20'h00888, 2'd0, 1'b1, 1'b1, 2'd0},
             pk(32'h0088_8100, 2'd0, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);

        // reset while in REFILL
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.vaddr = 32'h0090_0000; bus.is_store = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rr_in_refill", bus.tlb_req_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rr_state", dbg_state, ST_IDLE);
        chk("rr_out", {bus.resp_valid, bus.tlb_req_valid, observed()},
            {1'b0, 1'b0, pk(32'h0, 2'd0, 1'b0, 1'b0, EXC_NONE)});
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        bus.tlb_resp_valid = 1'b1; bus.tlb_found = 1'b1; bus.tlb_v = 1'b1; bus.tlb_pfn = 20'h00999;
        @(posedge clk); #1;
        bus.tlb_resp_valid = 1'b0;
        @(negedge clk);
        chk("stray_tlb_resp", {bus.resp_valid, bus.tlb_req_valid, 2'(dbg_state)},
            {1'b0, 1'b0, 2'(ST_IDLE)});

        // fill NUTLB+1 pages: the first one is evicted
        for (int i = 0; i <= NUTLB; i++) begin
            xact("fill", {20'h01000 + 20'(i), 12'h004}, 1'b0, 1'b1, 1,
                 '{1'b1, 20'h20000 + 20'(i), 2'd1, 1'b1, 1'b1, 2'd0},
                 pk({20'h20000 + 20'(i), 12'h004}, 2'd1, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);
        end
        xact("evict_keep", 32'h0100_1008, 1'b0, HIT_REFILL, 1,
             '{1'b1, 20'h20001, 2'd1, 1'b1, 1'b1, 2'd0},
             pk(32'h2000_1008, 2'd1, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);
        xact("evict_gone", 32'h0100_0008, 1'b0, 1'b1, 1,
             '{1'b1, 20'h20000, 2'd1, 1'b1, 1'b1, 2'd0},
             pk(32'h2000_0008, 2'd1, 1'b0, 1'b1, EXC_NONE), 0, 1'b0, 1'b0);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
